// File: rtl/m_wbone_latbank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m_wbone_latbank_if
// Purpose  : Classic wishbone slave-port bundle for the latency test bank.
// Ports    : STB_I/WE_I/SEL_I/ADR_I/DAT_I  master -> slave
//            ACK_O/DAT_O                   slave  -> master
// Revision : 1.0  initial release
// ============================================================================
interface m_wbone_latbank_if #(
    parameter int AW = 3
);
    logic          STB_I;
    logic          WE_I;
    logic [3:0]    SEL_I;
    logic [AW-1:0] ADR_I;
    logic [31:0]   DAT_I;
    logic          ACK_O;
    logic [31:0]   DAT_O;

    modport master (
        output STB_I, WE_I, SEL_I, ADR_I, DAT_I,
        input  ACK_O, DAT_O
    );

    modport slave (
        input  STB_I, WE_I, SEL_I, ADR_I, DAT_I,
        output ACK_O, DAT_O
    );
endinterface
`default_nettype wire

// File: rtl/m_wbone_latbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : m_wbone_latbank
// Purpose  : Wishbone test slave with a bank of byte-selectable 32-bit
//            registers and separately programmable read/write ACK latency,
//            optional auto-ramping latency and a completed-access counter.
//            Word 0 = CTRL, word 1 = ACKCNT (read-only), words 2.. = data.
// Ports    : CLK_I    clock
//            RST_I    asynchronous active-high reset
//            wb       wishbone slave port (STB/WE/SEL/ADR/DAT_I, ACK/DAT_O)
//            busy     high while an access waits for its latency to expire
//            regctrl  current CTRL contents
// Revision : 1.0  initial release
// ============================================================================
module m_wbone_latbank #(
    parameter int          AW                       = 3,
    parameter int          LATWIDTH                 = 6,
    parameter logic [31:0] RESETCTRL                = 32'h0,
    parameter bit          DAT_O_ZERO_WHEN_INACTIVE = 1'b1
) (
    input  wire           CLK_I,
    input  wire           RST_I,
    m_wbone_latbank_if.slave wb,
    output logic          busy,
    output logic [31:0]   regctrl
);
    localparam int          NWORDS      = 2 ** AW;
    localparam logic [31:0] C_LATMASK   = (32'd1 << LATWIDTH) - 32'd1;
    localparam logic [31:0] C_CTRLMASK  = 32'h0001_0000 | (C_LATMASK << 8) | C_LATMASK;
    localparam logic [AW-1:0] C_ADR_CTRL = '0;
    localparam logic [AW-1:0] C_ADR_CNT  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    logic [LATWIDTH-1:0] r_cnt;
    logic                r_we;
    logic [AW-1:0]       r_adr;
    logic [3:0]          r_sel;
    logic [31:0]         r_dat_in;
    logic                r_ack;
    logic [31:0]         r_rdata;
    logic [31:0]         r_ctrl;
    logic [31:0]         r_ackcnt;
    logic [31:0]         r_mem [NWORDS];

    logic [LATWIDTH-1:0] w_lat;
    logic [31:0]         w_wmask;
    logic [31:0]         w_rdword;
    logic [31:0]         w_ctrl_wr;
    logic [31:0]         w_mem_wr;

    // Latency is chosen from the live request, so a CTRL write only affects
    // accesses that start after it has committed.
    assign w_lat     = wb.WE_I ? r_ctrl[LATWIDTH-1:0] : r_ctrl[LATWIDTH+7:8];
    assign w_wmask   = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
    assign w_ctrl_wr = ((r_ctrl & ~w_wmask) | (r_dat_in & w_wmask)) & C_CTRLMASK;
    assign w_mem_wr  = (r_mem[r_adr] & ~w_wmask) | (r_dat_in & w_wmask);

    always_comb begin
        w_rdword = r_mem[r_adr];
        if (r_adr == C_ADR_CTRL) begin
            w_rdword = r_ctrl;
        end else if (r_adr == C_ADR_CNT) begin
            w_rdword = r_ackcnt;
        end
    end

    // S_ACK is the commit cycle; the registered ACK_O appears on the edge
    // that leaves it, so ACK_O rises L+1 edges after the request is sampled.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_dat_in <= '0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_ctrl   <= RESETCTRL & C_CTRLMASK;
            r_ackcnt <= '0;
            busy     <= 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb.STB_I) begin
                        r_we     <= wb.WE_I;
                        r_adr    <= wb.ADR_I;
                        r_sel    <= wb.SEL_I;
                        r_dat_in <= wb.DAT_I;
                        r_cnt    <= w_lat;
                        if (w_lat == '0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_WAIT;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb.STB_I) begin
                        // Master gave up: drop the access without side effects.
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_cnt == LATWIDTH'(1)) begin
                        r_state <= S_ACK;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - LATWIDTH'(1);
                    end
                end
                S_ACK: begin
                    r_state  <= S_IDLE;
                    r_ack    <= 1'b1;
                    r_ackcnt <= r_ackcnt + 32'd1;
                    r_rdata  <= r_we ? 32'd0 : w_rdword;
                    // An explicit CTRL write takes precedence over ramping.
                    if (r_we && (r_adr == C_ADR_CTRL)) begin
                        r_ctrl <= w_ctrl_wr;
                    end else if (r_ctrl[16]) begin
                        r_ctrl[LATWIDTH-1:0]   <= r_ctrl[LATWIDTH-1:0] + LATWIDTH'(1);
                        r_ctrl[LATWIDTH+7:8]   <= r_ctrl[LATWIDTH+7:8] + LATWIDTH'(1);
                    end
                    if (r_we && (r_adr != C_ADR_CTRL) && (r_adr != C_ADR_CNT)) begin
                        r_mem[r_adr] <= w_mem_wr;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign wb.ACK_O = r_ack;
    assign regctrl  = r_ctrl;

    generate
        if (DAT_O_ZERO_WHEN_INACTIVE) begin : g_dat_gated
            assign wb.DAT_O = r_ack ? r_rdata : 32'd0;
        end else begin : g_dat_raw
            assign wb.DAT_O = r_rdata;
        end
    endgenerate
endmodule
`default_nettype wire
